mem_xbar: RTL and testbench

Parametrised two-master, NSLV-slave memory crossbar between the CPU's instruction port (imemory) and data port (dmemory) and the on-chip slaves (iram, dram, timer, uart, …). It decodes addresses against per-slave windows and arbitrates same-slave conflicts. A losing request is held and replayed, not dropped. Responses are routed back per master, and unmapped accesses are answered with a decode error. It replaces the hand-written top-level mux in the CPU testbench and SoC tops.

---
 rtl/mem_xbar.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mem_xbar.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_xbar.sv
// mem_xbar: two-master (instruction / data) to NSLV-slave memory crossbar.
// Each master has its own IDLE/PEND/WAIT FSM, a hold register for requests that
// lose arbitration, and a registered decode-error flag. Requests and responses
// pass through combinationally once granted.
// Build option: define MEM_XBAR_RR_EN for per-slave round-robin on same-slave
// conflicts; left undefined, the data master always wins a conflict.

module mem_xbar #(
  parameter int                 NSLV     = 4,
  parameter logic [NSLV*32-1:0] SLV_BASE = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] SLV_MASK = {NSLV{32'h0}}
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               imemory_valid,
  input  logic               imemory_instr,
  input  logic [31:0]        imemory_addr,
  input  logic [31:0]        imemory_wdata,
  input  logic [3:0]         imemory_wstrb,
  output logic [31:0]        imemory_rdata,
  output logic               imemory_ready,
  output logic               imemory_err,

  input  logic               dmemory_valid,
  input  logic               dmemory_instr,
  input  logic [31:0]        dmemory_addr,
  input  logic [31:0]        dmemory_wdata,
  input  logic [3:0]         dmemory_wstrb,
  output logic [31:0]        dmemory_rdata,
  output logic               dmemory_ready,
  output logic               dmemory_err,

  output logic [NSLV-1:0]    slave_valid,
  output logic [NSLV-1:0]    slave_instr,
  output logic [NSLV*32-1:0] slave_addr,
  output logic [NSLV*32-1:0] slave_wdata,
  output logic [NSLV*4-1:0]  slave_wstrb,
  input  logic [NSLV*32-1:0] slave_rdata,
  input  logic [NSLV-1:0]    slave_ready
);

  localparam int TW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int MI = 0;
  localparam int MD = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_WAIT
  } state_t;

  // Live master inputs gathered into per-master arrays (index 0 = instr, 1 = data)
  logic        w_inValid [2];
  logic        w_inInstr [2];
  logic [31:0] w_inAddr  [2];
  logic [31:0] w_inWdata [2];
  logic [3:0]  w_inWstrb [2];

  assign w_inValid[MI] = imemory_valid;
  assign w_inInstr[MI] = imemory_instr;
  assign w_inAddr[MI]  = imemory_addr;
  assign w_inWdata[MI] = imemory_wdata;
  assign w_inWstrb[MI] = imemory_wstrb;

  assign w_inValid[MD] = dmemory_valid;
  assign w_inInstr[MD] = dmemory_instr;
  assign w_inAddr[MD]  = dmemory_addr;
  assign w_inWdata[MD] = dmemory_wdata;
  assign w_inWstrb[MD] = dmemory_wstrb;

  // Registered per-master state
  state_t      r_state     [2];
  logic [TW-1:0] r_tgt     [2];
  logic        r_err       [2];
  logic [31:0] r_holdAddr  [2];
  logic [31:0] r_holdWdata [2];
  logic [3:0]  r_holdWstrb [2];
  logic        r_holdInstr [2];

  // A slave stays busy from its grant until the edge that samples its ready
  logic [NSLV-1:0] r_busy;

`ifdef MEM_XBAR_RR_EN
  // Per slave: 1 = data master gets the next conflict, 0 = instruction master
  logic [NSLV-1:0] r_rrData;
`endif

  // Request presented by each master this cycle
  logic [TW:0]   w_liveDec   [2];
  logic          w_reqActive [2];
  logic          w_reqHit    [2];
  logic [TW-1:0] w_reqTgt    [2];
  logic [31:0]   w_reqAddr   [2];
  logic [31:0]   w_reqWdata  [2];
  logic [3:0]    w_reqWstrb  [2];
  logic          w_reqInstr  [2];

  logic [1:0]    w_want;
  logic [1:0]    w_grant;
  logic          w_conflict;
  logic          w_confWinData;

  logic          w_outReady [2];
  logic          w_outErr   [2];
  logic [31:0]   w_outRdata [2];

  // Address decode: returns {hit, index}; scanning downwards lets the lowest index win
  function automatic logic [TW:0] decode(input logic [31:0] addr);
    logic [TW:0] res;
    res = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr & ~SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
        res = {1'b1, TW'(i)};
      end
    end
    return res;
  endfunction

  // Choose what each master offers: the live request in IDLE, the held copy in PEND
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      w_liveDec[m] = decode(w_inAddr[m]);
      if (r_state[m] == S_PEND) begin
        w_reqActive[m] = 1'b1;
        w_reqHit[m]    = 1'b1;
        w_reqTgt[m]    = r_tgt[m];
        w_reqAddr[m]   = r_holdAddr[m];
        w_reqWdata[m]  = r_holdWdata[m];
        w_reqWstrb[m]  = r_holdWstrb[m];
        w_reqInstr[m]  = r_holdInstr[m];
      end else begin
        w_reqActive[m] = (r_state[m] == S_IDLE) && w_inValid[m];
        w_reqHit[m]    = w_liveDec[m][TW];
        w_reqTgt[m]    = w_liveDec[m][TW-1:0];
        w_reqAddr[m]   = w_inAddr[m];
        w_reqWdata[m]  = w_inWdata[m];
        w_reqWstrb[m]  = w_inWstrb[m];
        w_reqInstr[m]  = w_inInstr[m];
      end
    end
  end

  // Arbitration: a master wants a free decoded slave; same-slave collisions go to one winner
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      w_want[m] = w_reqActive[m] && w_reqHit[m] && !r_busy[w_reqTgt[m]];
    end
    w_conflict = w_want[MI] && w_want[MD] && (w_reqTgt[MI] == w_reqTgt[MD]);
`ifdef MEM_XBAR_RR_EN
    w_confWinData = r_rrData[w_reqTgt[MD]];
`else
    w_confWinData = 1'b1;
`endif
    w_grant[MI] = w_want[MI] && !(w_conflict && w_confWinData);
    w_grant[MD] = w_want[MD] && !(w_conflict && !w_confWinData);
  end

  // Slave-side request fields; a slave nobody is granted to sees all zeros
  always_comb begin
    slave_valid = '0;
    slave_instr = '0;
    slave_addr  = '0;
    slave_wdata = '0;
    slave_wstrb = '0;
    for (int m = 0; m < 2; m++) begin
      if (w_grant[m]) begin
        slave_valid[w_reqTgt[m]]              = 1'b1;
        slave_instr[w_reqTgt[m]]              = w_reqInstr[m];
        slave_addr[w_reqTgt[m]*32 +: 32]      = w_reqAddr[m] & SLV_MASK[w_reqTgt[m]*32 +: 32];
        slave_wdata[w_reqTgt[m]*32 +: 32]     = w_reqWdata[m];
        slave_wstrb[w_reqTgt[m]*4 +: 4]       = w_reqWstrb[m];
      end
    end
  end

  // Response routing: WAIT forwards the target's ready/rdata, or answers a decode error
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      w_outReady[m] = 1'b0;
      w_outErr[m]   = 1'b0;
      w_outRdata[m] = '0;
      if (r_state[m] == S_WAIT) begin
        if (r_err[m]) begin
          w_outReady[m] = 1'b1;
          w_outErr[m]   = 1'b1;
        end else if (slave_ready[r_tgt[m]]) begin
          w_outReady[m] = 1'b1;
          w_outRdata[m] = slave_rdata[r_tgt[m]*32 +: 32];
        end
      end
    end
  end

  assign imemory_ready = w_outReady[MI];
  assign imemory_err   = w_outErr[MI];
  assign imemory_rdata = w_outRdata[MI];
  assign dmemory_ready = w_outReady[MD];
  assign dmemory_err   = w_outErr[MD];
  assign dmemory_rdata = w_outRdata[MD];

  // Master FSMs, hold registers, slave busy flags and round-robin pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        r_state[m]     <= S_IDLE;
        r_tgt[m]       <= '0;
        r_err[m]       <= 1'b0;
        r_holdAddr[m]  <= '0;
        r_holdWdata[m] <= '0;
        r_holdWstrb[m] <= '0;
        r_holdInstr[m] <= 1'b0;
      end
      r_busy <= '0;
`ifdef MEM_XBAR_RR_EN
      r_rrData <= '1;
`endif
    end else begin
      r_busy <= (r_busy & ~slave_ready) | slave_valid;
`ifdef MEM_XBAR_RR_EN
      if (w_conflict) begin
        r_rrData[w_reqTgt[MD]] <= ~w_confWinData;
      end
`endif
      for (int m = 0; m < 2; m++) begin
        case (r_state[m])
          S_IDLE: begin
            if (w_inValid[m]) begin
              if (!w_reqHit[m]) begin
                r_state[m] <= S_WAIT;
                r_err[m]   <= 1'b1;
              end else begin
                r_tgt[m] <= w_reqTgt[m];
                r_err[m] <= 1'b0;
                if (w_grant[m]) begin
                  r_state[m] <= S_WAIT;
                end else begin
                  r_state[m]     <= S_PEND;
                  r_holdAddr[m]  <= w_inAddr[m];
                  r_holdWdata[m] <= w_inWdata[m];
                  r_holdWstrb[m] <= w_inWstrb[m];
                  r_holdInstr[m] <= w_inInstr[m];
                end
              end
            end
          end
          S_PEND: begin
            if (w_grant[m]) begin
              r_state[m] <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (r_err[m] || slave_ready[r_tgt[m]]) begin
              r_state[m] <= S_IDLE;
              r_err[m]   <= 1'b0;
            end
          end
          default: begin
            r_state[m] <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_xbar.sv
// tb_mem_xbar: directed bench for mem_xbar with four slaves whose responses are
// driven by hand. Inputs change on the falling edge; outputs are sampled 1 time
// unit later, well before the next rising edge.
// Expected conflict winners follow MEM_XBAR_RR_EN when it is defined.

module tb_mem_xbar;

  localparam int NSLV = 4;
  localparam logic [NSLV*32-1:0] BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NSLV*32-1:0] MASK = {32'h0000_000F, 32'h0000_00FF, 32'h0000_FFFF, 32'h0000_FFFF};

`ifdef MEM_XBAR_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               imemory_valid, imemory_instr;
  logic [31:0]        imemory_addr, imemory_wdata, imemory_rdata;
  logic [3:0]         imemory_wstrb;
  logic               imemory_ready, imemory_err;
  logic               dmemory_valid, dmemory_instr;
  logic [31:0]        dmemory_addr, dmemory_wdata, dmemory_rdata;
  logic [3:0]         dmemory_wstrb;
  logic               dmemory_ready, dmemory_err;
  logic [NSLV-1:0]    slave_valid, slave_instr, slave_ready;
  logic [NSLV*32-1:0] slave_addr, slave_wdata, slave_rdata;
  logic [NSLV*4-1:0]  slave_wstrb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_xbar #(
    .NSLV(NSLV),
    .SLV_BASE(BASE),
    .SLV_MASK(MASK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imemory_valid(imemory_valid),
    .imemory_instr(imemory_instr),
    .imemory_addr(imemory_addr),
    .imemory_wdata(imemory_wdata),
    .imemory_wstrb(imemory_wstrb),
    .imemory_rdata(imemory_rdata),
    .imemory_ready(imemory_ready),
    .imemory_err(imemory_err),
    .dmemory_valid(dmemory_valid),
    .dmemory_instr(dmemory_instr),
    .dmemory_addr(dmemory_addr),
    .dmemory_wdata(dmemory_wdata),
    .dmemory_wstrb(dmemory_wstrb),
    .dmemory_rdata(dmemory_rdata),
    .dmemory_ready(dmemory_ready),
    .dmemory_err(dmemory_err),
    .slave_valid(slave_valid),
    .slave_instr(slave_instr),
    .slave_addr(slave_addr),
    .slave_wdata(slave_wdata),
    .slave_wstrb(slave_wstrb),
    .slave_rdata(slave_rdata),
    .slave_ready(slave_ready)
  );

  // Compare one observed value with its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and let combinational outputs settle
  task automatic applyStimulus(input logic r,
                               input logic iv, input logic [31:0] ia, input logic [31:0] iw, input logic [3:0] is,
                               input logic dv, input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds,
                               input logic [NSLV-1:0] sr);
    @(negedge clk);
    rst           = r;
    imemory_valid = iv;
    imemory_instr = iv;
    imemory_addr  = ia;
    imemory_wdata = iw;
    imemory_wstrb = is;
    dmemory_valid = dv;
    dmemory_instr = 1'b0;
    dmemory_addr  = da;
    dmemory_wdata = dw;
    dmemory_wstrb = ds;
    slave_ready   = sr;
    #1;
  endtask

  task automatic idleCycle(input logic [NSLV-1:0] sr);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, sr);
  endtask

  initial begin
    bit winData;
    logic [31:0] iOff, dOff;

    rst = 1'b1;
    imemory_valid = 1'b0; imemory_instr = 1'b0; imemory_addr = '0; imemory_wdata = '0; imemory_wstrb = '0;
    dmemory_valid = 1'b0; dmemory_instr = 1'b0; dmemory_addr = '0; dmemory_wdata = '0; dmemory_wstrb = '0;
    slave_ready = '0;
    slave_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};

    // Reset state
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0000);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0000);
    idleCycle(4'b0000);
    checkOutput("rst_svalid", 64'(slave_valid), 64'h0);
    checkOutput("rst_ready", 64'({imemory_ready, dmemory_ready}), 64'h0);
    checkOutput("rst_err", 64'({imemory_err, dmemory_err}), 64'h0);
    checkOutput("rst_rdata", {imemory_rdata, dmemory_rdata}, 64'h0);

    // Instruction read of slave 0 base+0x10, answered two cycles later
    applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0000);
    checkOutput("t1_svalid", 64'(slave_valid), 64'h1);
    checkOutput("t1_saddr", 64'(slave_addr[31:0]), 64'h10);
    checkOutput("t1_sinstr", 64'(slave_instr[0]), 64'h1);
    checkOutput("t1_irdy_early", 64'(imemory_ready), 64'h0);
    idleCycle(4'b0000);
    checkOutput("t1_svalid_once", 64'(slave_valid), 64'h0);
    idleCycle(4'b0001);
    checkOutput("t1_irdy", 64'(imemory_ready), 64'h1);
    checkOutput("t1_irdata", 64'(imemory_rdata), 64'hDEAD_BEEF);
    checkOutput("t1_ierr", 64'(imemory_err), 64'h0);
    idleCycle(4'b0000);
    checkOutput("t1_irdy_pulse", 64'(imemory_ready), 64'h0);

    // Both masters hit slave 1: data first, instruction replayed from its hold register
    applyStimulus(1'b0, 1'b1, 32'h1000_0020, 32'hAAAA_0001, 4'hF,
                  1'b1, 32'h1000_0030, 32'hBBBB_0002, 4'h0, 4'b0000);
    checkOutput("t2_svalid", 64'(slave_valid), 64'h2);
    checkOutput("t2_saddr_d", 64'(slave_addr[63:32]), 64'h30);
    checkOutput("t2_swdata_d", 64'(slave_wdata[63:32]), 64'hBBBB_0002);
    checkOutput("t2_swstrb_d", 64'(slave_wstrb[7:4]), 64'h0);
    idleCycle(4'b0000);
    checkOutput("t2_busy_hold", 64'(slave_valid), 64'h0);
    idleCycle(4'b0010);
    checkOutput("t2_drdy", 64'({imemory_ready, dmemory_ready}), 64'h1);
    checkOutput("t2_drdata", 64'(dmemory_rdata), 64'h1111_1111);
    checkOutput("t2_no_early_replay", 64'(slave_valid), 64'h0);
    idleCycle(4'b0000);
    checkOutput("t2_replay_valid", 64'(slave_valid), 64'h2);
    checkOutput("t2_replay_addr", 64'(slave_addr[63:32]), 64'h20);
    checkOutput("t2_replay_wdata", 64'(slave_wdata[63:32]), 64'hAAAA_0001);
    checkOutput("t2_replay_wstrb", 64'(slave_wstrb[7:4]), 64'hF);
    checkOutput("t2_replay_instr", 64'(slave_instr[1]), 64'h1);
    idleCycle(4'b0010);
    checkOutput("t2_irdy", 64'({imemory_ready, dmemory_ready}), 64'h2);
    checkOutput("t2_irdata", 64'(imemory_rdata), 64'h1111_1111);

    // Repeat the slave 1 conflict twice more; round-robin alternates the winner
    for (int k = 1; k <= 2; k++) begin
      winData = RR ? (k != 1) : 1'b1;
      iOff = 32'h100 + 32'(k);
      dOff = 32'h200 + 32'(k);
      applyStimulus(1'b0, 1'b1, 32'h1000_0000 | iOff, 32'h0, 4'h0,
                    1'b1, 32'h1000_0000 | dOff, 32'h0, 4'h0, 4'b0000);
      checkOutput($sformatf("rr%0d_win_addr", k), 64'(slave_addr[63:32]), 64'(winData ? dOff : iOff));
      checkOutput($sformatf("rr%0d_win_instr", k), 64'(slave_instr[1]), 64'(!winData));
      idleCycle(4'b0010);
      checkOutput($sformatf("rr%0d_win_rdy", k), 64'({imemory_ready, dmemory_ready}), winData ? 64'h1 : 64'h2);
      idleCycle(4'b0000);
      checkOutput($sformatf("rr%0d_lose_valid", k), 64'(slave_valid), 64'h2);
      checkOutput($sformatf("rr%0d_lose_addr", k), 64'(slave_addr[63:32]), 64'(winData ? iOff : dOff));
      idleCycle(4'b0010);
      checkOutput($sformatf("rr%0d_lose_rdy", k), 64'({imemory_ready, dmemory_ready}), winData ? 64'h2 : 64'h1);
    end

    // Instruction to slave 0 and data store to slave 2 together: independent paths
    applyStimulus(1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'h0,
                  1'b1, 32'h2000_0004, 32'h1234_5678, 4'h3, 4'b0000);
    checkOutput("t4_svalid", 64'(slave_valid), 64'h5);
    checkOutput("t4_saddr0", 64'(slave_addr[31:0]), 64'h40);
    checkOutput("t4_saddr2", 64'(slave_addr[95:64]), 64'h4);
    checkOutput("t4_swdata2", 64'(slave_wdata[95:64]), 64'h1234_5678);
    checkOutput("t4_swstrb2", 64'(slave_wstrb[11:8]), 64'h3);
    idleCycle(4'b0100);
    checkOutput("t4_drdy", 64'({imemory_ready, dmemory_ready}), 64'h1);
    checkOutput("t4_drdata", 64'(dmemory_rdata), 64'h2222_2222);
    idleCycle(4'b0001);
    checkOutput("t4_irdy", 64'({imemory_ready, dmemory_ready}), 64'h2);
    checkOutput("t4_irdata", 64'(imemory_rdata), 64'hDEAD_BEEF);

    // Data store to an unmapped address answers with a decode error one cycle later
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h4000_0000, 32'h5555_5555, 4'hF, 4'b0000);
    checkOutput("t5_svalid", 64'(slave_valid), 64'h0);
    checkOutput("t5_drdy_early", 64'(dmemory_ready), 64'h0);
    idleCycle(4'b0000);
    checkOutput("t5_drdy_err", 64'({dmemory_ready, dmemory_err}), 64'h3);
    checkOutput("t5_drdata", 64'(dmemory_rdata), 64'h0);
    idleCycle(4'b0000);
    checkOutput("t5_drdy_pulse", 64'({dmemory_ready, dmemory_err}), 64'h0);

    // One byte past slave 2's 256-byte window is unmapped
    applyStimulus(1'b0, 1'b1, 32'h2000_0100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0000);
    checkOutput("t5b_svalid", 64'(slave_valid), 64'h0);
    idleCycle(4'b0000);
    checkOutput("t5b_irdy_err", 64'({imemory_ready, imemory_err}), 64'h3);

    // Reset while instruction waits on slave 3 and data is pending on it
    applyStimulus(1'b0, 1'b1, 32'h3000_000F, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0000);
    checkOutput("t6_svalid", 64'(slave_valid), 64'h8);
    checkOutput("t6_saddr_top", 64'(slave_addr[127:96]), 64'hF);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h3000_000C, 32'h0, 4'h0, 4'b0000);
    checkOutput("t6_busy", 64'(slave_valid), 64'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0000);
    idleCycle(4'b0000);
    checkOutput("t6_post_svalid", 64'(slave_valid), 64'h0);
    checkOutput("t6_post_ready", 64'({imemory_ready, dmemory_ready, imemory_err, dmemory_err}), 64'h0);
    idleCycle(4'b1000);
    checkOutput("t6_late_ready", 64'({imemory_ready, dmemory_ready}), 64'h0);
    checkOutput("t6_no_replay", 64'(slave_valid), 64'h0);
    applyStimulus(1'b0, 1'b1, 32'h3000_0004, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0000);
    checkOutput("t6_fresh_valid", 64'(slave_valid), 64'h8);
    idleCycle(4'b1000);
    checkOutput("t6_fresh_rdy", 64'({imemory_ready, dmemory_ready}), 64'h2);
    checkOutput("t6_fresh_rdata", 64'(imemory_rdata), 64'h3333_3333);

    idleCycle(4'b0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
